// File: rtl/dma_csr_pkg.sv
// Shared register map, reset values and APB slave state encoding for the
// dma_apb_csr register file.
package dma_csr_pkg;

    localparam logic [31:0] CTRL_OFFSET     = 32'h000;
    localparam logic [31:0] STATUS_OFFSET   = 32'h004;
    localparam logic [31:0] ERR_ADDR_OFFSET = 32'h008;
    localparam logic [31:0] INT_EN_OFFSET   = 32'h00C;

    localparam logic [31:0] DESC_BASE   = 32'h100;
    localparam logic [31:0] DESC_STRIDE = 32'h020;

    localparam logic [4:0] DESC_CFG_OFFSET     = 5'h00;
    localparam logic [4:0] DESC_SRC_OFFSET     = 5'h04;
    localparam logic [4:0] DESC_DST_OFFSET     = 5'h08;
    localparam logic [4:0] DESC_NUM_OFFSET     = 5'h0C;
    localparam logic [4:0] DESC_RD_JUMP_OFFSET = 5'h10;
    localparam logic [4:0] DESC_WR_JUMP_OFFSET = 5'h14;

    localparam logic [7:0] MAXBURST_RST = 8'h0F;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdDone
    } apb_state_e;

endpackage

// File: rtl/dma_csr_desc_bank.sv
// Register bank for one DMA descriptor: six fields, their write decode and
// a read mux that outputs zero when the address is not one of its fields.
module dma_csr_desc_bank import dma_csr_pkg::*; #(
    parameter int unsigned DescIdx    = 0,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned BytesWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           addr_i,
    input  logic                  wr_en_i,
    input  logic [31:0]           wdata_i,
    output logic                  hit_o,
    output logic [31:0]           rdata_o,
    output logic                  enable_o,
    output logic                  read_mode_o,
    output logic                  write_mode_o,
    output logic [AddrWidth-1:0]  src_addr_o,
    output logic [AddrWidth-1:0]  dst_addr_o,
    output logic [BytesWidth-1:0] num_bytes_o,
    output logic [BytesWidth-1:0] rd_jump_o,
    output logic [BytesWidth-1:0] wr_jump_o
);

    localparam logic [31:0] BlockBase = DESC_BASE + DescIdx * DESC_STRIDE;

    logic [2:0]            cfg_q;
    logic [AddrWidth-1:0]  src_q, dst_q;
    logic [BytesWidth-1:0] num_q, rdj_q, wrj_q;
    logic                  in_blk;
    logic [4:0]            off;

    assign in_blk = (addr_i[31:5] == BlockBase[31:5]);
    assign off    = addr_i[4:0];

    always_comb begin
        hit_o   = 1'b0;
        rdata_o = '0;
        if (in_blk) begin
            unique case (off)
                DESC_CFG_OFFSET:     begin hit_o = 1'b1; rdata_o = {29'b0, cfg_q}; end
                DESC_SRC_OFFSET:     begin hit_o = 1'b1; rdata_o = 32'(src_q);     end
                DESC_DST_OFFSET:     begin hit_o = 1'b1; rdata_o = 32'(dst_q);     end
                DESC_NUM_OFFSET:     begin hit_o = 1'b1; rdata_o = 32'(num_q);     end
                DESC_RD_JUMP_OFFSET: begin hit_o = 1'b1; rdata_o = 32'(rdj_q);     end
                DESC_WR_JUMP_OFFSET: begin hit_o = 1'b1; rdata_o = 32'(wrj_q);     end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q <= '0;
            src_q <= '0;
            dst_q <= '0;
            num_q <= '0;
            rdj_q <= '0;
            wrj_q <= '0;
        end else if (wr_en_i && hit_o) begin
            unique case (off)
                DESC_CFG_OFFSET:     cfg_q <= wdata_i[2:0];
                DESC_SRC_OFFSET:     src_q <= wdata_i[AddrWidth-1:0];
                DESC_DST_OFFSET:     dst_q <= wdata_i[AddrWidth-1:0];
                DESC_NUM_OFFSET:     num_q <= wdata_i[BytesWidth-1:0];
                DESC_RD_JUMP_OFFSET: rdj_q <= wdata_i[BytesWidth-1:0];
                DESC_WR_JUMP_OFFSET: wrj_q <= wdata_i[BytesWidth-1:0];
                default: ;
            endcase
        end
    end

    assign enable_o     = cfg_q[0];
    assign read_mode_o  = cfg_q[1];
    assign write_mode_o = cfg_q[2];
    assign src_addr_o   = src_q;
    assign dst_addr_o   = dst_q;
    assign num_bytes_o  = num_q;
    assign rd_jump_o    = rdj_q;
    assign wr_jump_o    = wrj_q;

endmodule

// File: rtl/dma_apb_csr.sv
// APB3 register file in front of dma_core: global control/status, per-descriptor
// banks, start/err_clr pulses and a registered level interrupt.
module dma_apb_csr import dma_csr_pkg::*; #(
    parameter int unsigned DMA_ADDR_WIDTH  = 32,
    parameter int unsigned DMA_BYTES_WIDTH = 32,
    parameter int unsigned DMA_NUM_DESC    = 8,
    parameter int unsigned APB_ADDR_WIDTH  = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          psel,
    input  logic                                          penable,
    input  logic                                          pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]                     paddr,
    input  logic [31:0]                                   pwdata,
    output logic [31:0]                                   prdata,
    output logic                                          pready,
    output logic                                          pslverr,
    output logic [DMA_NUM_DESC-1:0]                       csr_desc_enable,
    output logic [DMA_NUM_DESC-1:0]                       csr_desc_read_mode,
    output logic [DMA_NUM_DESC-1:0]                       csr_desc_write_mode,
    output logic [DMA_NUM_DESC-1:0][DMA_ADDR_WIDTH-1:0]   csr_desc_src_addr,
    output logic [DMA_NUM_DESC-1:0][DMA_ADDR_WIDTH-1:0]   csr_desc_dst_addr,
    output logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]  csr_desc_num_bytes,
    output logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]  csr_desc_read_jump_bytes,
    output logic [DMA_NUM_DESC-1:0][DMA_BYTES_WIDTH-1:0]  csr_desc_write_jump_bytes,
    output logic [7:0]                                    csr_dma_maxburst,
    output logic                                          csr_dma_start,
    output logic                                          csr_dma_err_clr,
    input  logic                                          csr_dma_done,
    input  logic                                          csr_dma_err,
    input  logic [1:0]                                    csr_dma_status,
    input  logic [1:0]                                    csr_dma_err_type,
    input  logic [DMA_ADDR_WIDTH-1:0]                     csr_dma_err_addr,
    output logic                                          irq
);

    apb_state_e  state_q;
    logic [31:0] prdata_q, rd_mux, addr;
    logic        rd_err_q;
    logic [7:0]  maxburst_q;
    logic [1:0]  int_en_q;
    logic        start_q, err_clr_q, done_d1_q, done_sticky_q, done_sticky_d, irq_q;
    logic        busy, wr_acc, rd_start, mapped, wr_err, bank_we, desc_hit;
    logic        hit_ctrl, hit_status, hit_err_addr, hit_int_en;
    logic [DMA_NUM_DESC-1:0]       bank_hit;
    logic [DMA_NUM_DESC-1:0][31:0] bank_rdata;
    logic        unused_bits;

    assign unused_bits = ^paddr[1:0];
    assign addr        = 32'({paddr[APB_ADDR_WIDTH-1:2], 2'b00});

    assign busy     = (csr_dma_status == 2'b01) || (csr_dma_status == 2'b10);
    assign wr_acc   = psel & penable & pwrite & (state_q == StIdle);
    assign rd_start = psel & penable & ~pwrite & (state_q == StIdle);

    assign hit_ctrl     = (addr == CTRL_OFFSET);
    assign hit_status   = (addr == STATUS_OFFSET);
    assign hit_err_addr = (addr == ERR_ADDR_OFFSET);
    assign hit_int_en   = (addr == INT_EN_OFFSET);
    assign desc_hit     = |bank_hit;
    assign mapped       = hit_ctrl | hit_status | hit_err_addr | hit_int_en | desc_hit;

    // CTRL writes while busy are flagged but still carry ERR_CLR through.
    assign wr_err  = ~mapped | (busy & (hit_ctrl | desc_hit));
    assign bank_we = wr_acc & ~busy;

    for (genvar i = 0; i < DMA_NUM_DESC; i++) begin : g_desc
        dma_csr_desc_bank #(
            .DescIdx    (i),
            .AddrWidth  (DMA_ADDR_WIDTH),
            .BytesWidth (DMA_BYTES_WIDTH)
        ) u_bank (
            .clk_i        (clk),
            .rst_i        (rst),
            .addr_i       (addr),
            .wr_en_i      (bank_we),
            .wdata_i      (pwdata),
            .hit_o        (bank_hit[i]),
            .rdata_o      (bank_rdata[i]),
            .enable_o     (csr_desc_enable[i]),
            .read_mode_o  (csr_desc_read_mode[i]),
            .write_mode_o (csr_desc_write_mode[i]),
            .src_addr_o   (csr_desc_src_addr[i]),
            .dst_addr_o   (csr_desc_dst_addr[i]),
            .num_bytes_o  (csr_desc_num_bytes[i]),
            .rd_jump_o    (csr_desc_read_jump_bytes[i]),
            .wr_jump_o    (csr_desc_write_jump_bytes[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        if (hit_ctrl)     rd_mux = {16'h0, maxburst_q, 8'h0};
        if (hit_status)   rd_mux = {26'h0, csr_dma_err_type, csr_dma_err, done_sticky_q,
                                    csr_dma_status};
        if (hit_err_addr) rd_mux = 32'(csr_dma_err_addr);
        if (hit_int_en)   rd_mux = {30'h0, int_en_q};
        for (int unsigned i = 0; i < DMA_NUM_DESC; i++) begin
            rd_mux = rd_mux | bank_rdata[i];
        end
    end

    // A fresh done edge beats a simultaneous W1C.
    assign done_sticky_d = (csr_dma_done & ~done_d1_q) |
                           (done_sticky_q & ~(wr_acc & hit_status & pwdata[2]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            prdata_q      <= '0;
            rd_err_q      <= 1'b0;
            maxburst_q    <= MAXBURST_RST;
            int_en_q      <= '0;
            start_q       <= 1'b0;
            err_clr_q     <= 1'b0;
            done_d1_q     <= 1'b0;
            done_sticky_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            done_d1_q     <= csr_dma_done;
            done_sticky_q <= done_sticky_d;
            irq_q         <= (done_sticky_q & int_en_q[0]) | (csr_dma_err & int_en_q[1]);
            start_q       <= wr_acc & hit_ctrl & ~busy & pwdata[0];
            err_clr_q     <= wr_acc & hit_ctrl & pwdata[1];
            if (wr_acc && hit_ctrl && !busy) maxburst_q <= pwdata[15:8];
            if (wr_acc && hit_int_en)        int_en_q   <= pwdata[1:0];
            unique case (state_q)
                StIdle: begin
                    if (rd_start) begin
                        state_q  <= StRdWait;
                        prdata_q <= rd_mux;
                        rd_err_q <= ~mapped;
                    end
                end
                StRdWait: state_q <= StRdDone;
                StRdDone: begin
                    state_q  <= StIdle;
                    prdata_q <= '0;
                    rd_err_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign prdata           = prdata_q;
    assign pready           = wr_acc | (state_q == StRdWait);
    assign pslverr          = (wr_acc & wr_err) | ((state_q == StRdWait) & rd_err_q);
    assign csr_dma_maxburst = maxburst_q;
    assign csr_dma_start    = start_q;
    assign csr_dma_err_clr  = err_clr_q;
    assign irq              = irq_q;

endmodule

// File: doc/dma_apb_csr.md
# dma_apb_csr

APB3 slave register file sitting directly upstream of `dma_core`. It holds the per-descriptor configuration arrays and the global `maxburst` value, and drives them onto the core's `csr_*` inputs. It turns software writes into single-cycle `csr_dma_start` / `csr_dma_err_clr` pulses, captures core status and errors for readback, and raises a level interrupt.

## Interface
- `DMA_ADDR_WIDTH`, default 32: descriptor address width; must be ≤ 32.
- `DMA_BYTES_WIDTH`, default 32: byte-count and jump width; must be ≤ 32.
- `DMA_NUM_DESC`, default 8: number of descriptors; must be ≤ 16.
- `APB_ADDR_WIDTH`, default 12: `paddr` width.
- Reset convention (already decided): one clock, and reset is asynchronous and active-high. Ports are `clk` and `rst`.
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-high reset.
- `psel`, `penable`, `pwrite`, in, 1 each: APB3 control.
- `paddr`, in, `APB_ADDR_WIDTH`: byte address; bits [1:0] are ignored.
- `pwdata`, in, 32: write data.
- `prdata`, out, 32: read data.
- `pready`, out, 1: transfer complete.
- `pslverr`, out, 1: error response.
- `csr_desc_enable`, `csr_desc_read_mode`, `csr_desc_write_mode`, out, 1 x `DMA_NUM_DESC`: per-descriptor flags.
- `csr_desc_src_addr`, `csr_desc_dst_addr`, out, `DMA_ADDR_WIDTH` x `DMA_NUM_DESC`: source and destination addresses.
- `csr_desc_num_bytes`, `csr_desc_read_jump_bytes`, `csr_desc_write_jump_bytes`, out, `DMA_BYTES_WIDTH` x `DMA_NUM_DESC`: byte count and jump strides.
- `csr_dma_maxburst`, out, 8: maximum burst length.
- `csr_dma_start`, `csr_dma_err_clr`, out, 1: one-cycle pulses.
- `csr_dma_done`, `csr_dma_err`, in, 1: core completion and error.
- `csr_dma_status`, in, 2: core state (00 idle, 01 check, 10 run, 11 done).
- `csr_dma_err_type`, in, 2: core error type.
- `csr_dma_err_addr`, in, `DMA_ADDR_WIDTH`: core error address.
- `irq`, out, 1: level interrupt.

## Operation

Register map:
- 0x000 CTRL: bit0 START (write-1 pulse, reads 0); bit1 ERR_CLR (write-1 pulse, reads 0); [15:8] MAXBURST (RW, reset 0x0F).
- 0x004 STATUS:
  - [1:0] core status (RO).
  - bit2 DONE_STICKY (W1C).
  - bit3 ERR (RO).
  - [5:4] ERR_TYPE (RO).
- 0x008 ERR_ADDR: RO, zero-extended to 32 bits.
- 0x00C INT_EN: bit0 DONE_IE, bit1 ERR_IE; RW, reset 0.
- 0x100 + 0x20·i, descriptor i:
  - +0x00: bit0 enable, bit1 read_mode, bit2 write_mode.
  - +0x04 src, +0x08 dst, +0x0C num_bytes, +0x10 rd_jump, +0x14 wr_jump.
  - All RW, reset 0; bits beyond the field width read 0.

Behaviour:
- DONE_STICKY is set on a 0→1 edge of `csr_dma_done`, sampled with a 1-cycle delay register.
- `irq` = (DONE_STICKY & DONE_IE) | (`csr_dma_err` & ERR_IE), driven from a register.
- While status ∈ {01, 10}, writes to descriptor space, MAXBURST or START are not applied and return `pslverr`=1. Writes to ERR_CLR, INT_EN and STATUS are still applied.
- START written while busy: no pulse is generated.
- An unmapped address, on read or write, returns `pslverr`=1 and `prdata`=0.
- A single write with START=1 and ERR_CLR=1 pulses both in the same cycle.
- A DONE edge and a W1C of DONE_STICKY in the same cycle: set wins.

## Timing
- Write: zero wait states; `pready`=1 in the first access cycle. The register updates, and any start/err_clr pulse is asserted, on the cycle after that access edge.
- Read: one wait state, via a slave FSM:
  - IDLE → RD_WAIT on `psel&penable&!pwrite`, with `pready`=0 and the read mux captured into a register.
  - RD_WAIT → RD_DONE, with `pready`=1 and registered `prdata`.
  - RD_DONE → IDLE.
- `pslverr` is valid only while `pready`=1; otherwise it is 0.
- `csr_dma_start` and `csr_dma_err_clr` are high for exactly one clock.
- `irq` latency: 2 cycles after a `csr_dma_done` edge (edge register, then the irq register).
- Reset values, asynchronous to `rst`:
  - All outputs are 0, except `csr_dma_maxburst`=0x0F.
  - FSM is in IDLE; edge register is 0.
- Reset asserted mid-transfer aborts it; the master must restart.

## Structure
- Package `dma_csr_pkg` holds: register offsets (CTRL, STATUS, ERR_ADDR, INT_EN), `DESC_BASE`=0x100, `DESC_STRIDE`=0x20, descriptor field offsets, and the MAXBURST reset value.
- One sub-module, `dma_csr_desc_bank`, instantiated per descriptor through a generate loop. It holds the 6 registers for one descriptor and provides its write-enable decode and read mux.

## Test plan
- Reset, then read 0x000 → 0x00000F00; read 0x004 → 0; `irq`=0; all descriptor outputs are 0.
- Write desc 2 src=0x8000_0040, num_bytes=0x100, enable=1 → `csr_desc_src_addr[2]`=0x80000040 the next cycle; read back matches, with `pready` low for exactly 1 cycle.
- Write CTRL=0x1 while status=00 → `csr_dma_start` high for 1 cycle. Force status=10 and write CTRL=0x1 and desc 0 src → no pulse, `pslverr`=1, desc 0 unchanged.
- Set DONE_IE=1 and pulse `csr_dma_done` → DONE_STICKY=1 and `irq`=1 after 2 cycles. W1C of STATUS bit2 in the same cycle as a second done edge → bit stays 1.
- Drive `csr_dma_err`=1, `err_type`=10, `err_addr`=0x1234 with ERR_IE=1 → `irq`=1; STATUS reads 0x28 (bits 5:4=10, bit3=1); write CTRL=0x2 → `csr_dma_err_clr` pulses 1 cycle.
- Read 0x020 (unmapped) → `pslverr`=1, `prdata`=0. Assert `rst` during the RD_WAIT state → FSM returns to IDLE and `pready`=0.
